tracker_sequencer: RTL and testbench
====================================

Name: tracker_sequencer

Overview:
Pattern sequencer that sits directly upstream of the tracker voice. It holds a small pattern of note rows, each a note_tp plus a speed, and steps through them at a programmable row length. Each row is presented on the note/speed inputs of the tracker for exactly row_len cycles. It supports host loading of the pattern, start/stop control, and optional looping.

Parameters:
ROWS, 64, number of pattern rows; RLEN = $clog2(ROWS)
MAXSPEED, 16, matches the tracker speed range; SPLEN = $clog2(MAXSPEED)
MAXROWLEN, 65536, maximum cycles per row; TCLEN = $clog2(MAXROWLEN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  pattern write strobe
wr_addr  in  RLEN  pattern row to write
wr_note  in  note_tp  note written to the row
wr_speed  in  SPLEN  speed written to the row
start  in  1  one-cycle pulse: begin (or restart) at row 0
stop  in  1  one-cycle pulse: halt and silence
loop_en  in  1  wrap to row 0 after last_row instead of ending
last_row  in  RLEN  final row index; values >= ROWS clamp to ROWS-1
row_len  in  TCLEN  cycles per row; sampled at each row boundary; values 0 or 1 act as 2
note  out  note_tp  current note to the tracker
speed  out  SPLEN  current speed to the tracker
row  out  RLEN  index of the presented row
playing  out  1  high while in PLAY or FETCH
row_strobe  out  1  one-cycle pulse in the first cycle a new row is presented
done  out  1  one-cycle pulse when a non-looping pattern finishes

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - note = SILENT_NOTE (all zero), speed = 0, row = 0.
  - playing = row_strobe = done = 0.
  - Pattern memory is not reset.
- Pattern memory: one synchronous write port and one synchronous read port; read latency 1.
  - A read and a write to the same address in the same cycle return the old data (read-first).
  - Writes are allowed in any state.
  - A write to a row that is already prefetched does not affect that row's playback in the current pass.
- States:
  - IDLE: outputs silent. start -> FETCH, with read pointer = 0.
  - FETCH: waits one cycle for read data, then loads note/speed/row from row 0, pulses row_strobe, clears the row counter -> PLAY. The read pointer advances to the next row (prefetch).
  - PLAY: the row counter increments each cycle. When the counter equals eff_row_len-1 and the presented row != last_row, the next row's data moves from the prefetch register to the outputs. On that same edge: row_strobe pulses, the counter clears, row_len is resampled, and the prefetch advances.
  - End of pattern (counter expires on last_row):
    - loop_en = 1: present row 0 and continue; row 0 must already be prefetched, so there is no gap.
    - loop_en = 0: -> IDLE, outputs silent, done pulses for 1 cycle.
- Timing:
  - start sampled at edge E0 -> row 0 is on the outputs after edge E0+2, with row_strobe high in that cycle.
  - Row k appears exactly eff_row_len cycles after row k-1.
  - done asserts eff_row_len cycles after the final row appeared.
- stop in FETCH/PLAY: -> IDLE at the next edge, outputs silent, no done. stop in IDLE has no effect.
- start in FETCH/PLAY: restart from row 0 with the same 2-cycle latency; no done.
- start and stop in the same cycle: stop wins.
- Row counter width is TCLEN and never wraps, because it clears at eff_row_len-1.

Decomposition:
- Shared package tracker_pkg contains:
  - instrument_t and effect_t
  - note_tp
  - localparam SILENT_NOTE (note_tp'0)
  - the SPLEN derivation helper, so the tracker and sequencer agree on widths
- Sub-module pattern_ram:
  - ROWS x ($bits(note_tp)+SPLEN)
  - synchronous write and read-first synchronous read
  - instantiated once

Test Plan:
- Load rows 0..3 with speeds 1,2,3,4; row_len=4, last_row=3, loop_en=0; start at cycle 0 -> rows appear at cycles 2,6,10,14 with speed 1..4 and row_strobe on each; done at cycle 18; outputs then 0 and playing=0.
- Same load with loop_en=1 -> after row 3 (cycle 14), row 0 reappears at cycle 18 with speed 1; no done; stop at cycle 20 -> silent at cycle 21.
- row_len=0 with last_row=1 -> rows spaced 2 cycles apart (cycles 2,4), done at cycle 6.
- start pulsed again at cycle 7 while playing row 1 -> row 0 presented at cycle 9; start and stop in the same cycle -> IDLE, no done.
- Write row 1 to speed 9 while row 0 is presented (row 1 already prefetched) -> the current pass plays the old speed; the next loop plays 9.
- Assert rst_n low mid-row at cycle 5 -> outputs immediately 0, playing=0; after release, memory contents persist and start replays from row 0.

Source files
------------

// File: rtl/tracker_pkg.sv
// Shared tracker types: note encoding, silent note and the speed-width helper
// used by both the tracker voice and the pattern sequencer.
package tracker_pkg;

    typedef enum logic [1:0] {
        INST_SQUARE,
        INST_SAW,
        INST_TRI,
        INST_NOISE
    } instrument_t;

    typedef enum logic [1:0] {
        FX_NONE,
        FX_ARP,
        FX_SLIDE,
        FX_VIBRATO
    } effect_t;

    typedef struct packed {
        logic [5:0]  pitch;
        instrument_t instr;
        effect_t     fx;
    } note_tp;

    localparam note_tp SILENT_NOTE = note_tp'(0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY
    } seq_state_t;

    // A speed range of 1 still needs one bit of storage.
    function automatic int speed_bits(input int maxspeed);
        return (maxspeed > 1) ? $clog2(maxspeed) : 1;
    endfunction

endpackage

// File: rtl/pattern_ram.sv
// Pattern row storage: one synchronous write port and one read-first
// synchronous read port with an enable, so the read register holds a prefetch.
module pattern_ram #(
    parameter  int ROWS  = 64,
    parameter  int WIDTH = 14,
    localparam int AW    = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [ROWS];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/tracker_sequencer.sv
// Pattern sequencer feeding note/speed rows to the tracker voice, one row
// every eff_row_len cycles, with start/stop control and optional looping.
//
// state   | meaning
// S_IDLE  | outputs silent, waiting for start
// S_FETCH | row 0 read in flight (r_wait=1), then row 0 presented
// S_PLAY  | row on outputs, next row held in the RAM read register
module tracker_sequencer
    import tracker_pkg::*;
#(
    parameter  int ROWS      = 64,
    parameter  int MAXSPEED  = 16,
    parameter  int MAXROWLEN = 65536,
    localparam int RLEN      = $clog2(ROWS),
    localparam int SPLEN     = speed_bits(MAXSPEED),
    localparam int TCLEN     = $clog2(MAXROWLEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [RLEN-1:0]  wr_addr,
    input  note_tp           wr_note,
    input  logic [SPLEN-1:0] wr_speed,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [RLEN-1:0]  last_row,
    input  logic [TCLEN-1:0] row_len,
    output note_tp           note,
    output logic [SPLEN-1:0] speed,
    output logic [RLEN-1:0]  row,
    output logic             playing,
    output logic             row_strobe,
    output logic             done
);

    localparam int NW = $bits(note_tp);
    localparam int DW = NW + SPLEN;

    seq_state_t       r_state;
    logic             r_wait;
    logic [TCLEN-1:0] r_cnt;
    logic [TCLEN-1:0] r_len_m1;

    logic [RLEN-1:0]  w_last;
    logic [RLEN-1:0]  w_next_row;
    logic [TCLEN-1:0] w_len_m1;
    logic             w_boundary;
    logic             w_end;
    logic             w_rd_en;
    logic [RLEN-1:0]  w_rd_addr;
    logic [DW-1:0]    w_rd_data;
    note_tp           w_rd_note;
    logic [SPLEN-1:0] w_rd_speed;

    function automatic logic [RLEN-1:0] nxt(input logic [RLEN-1:0] r,
                                            input logic [RLEN-1:0] last);
        return (r == last) ? '0 : r + RLEN'(1);
    endfunction

    assign w_last     = (int'(last_row) >= ROWS) ? RLEN'(ROWS - 1) : last_row;
    assign w_len_m1   = (row_len < TCLEN'(2)) ? TCLEN'(1) : row_len - TCLEN'(1);
    assign w_next_row = nxt(row, w_last);
    assign w_boundary = (r_state == S_PLAY) && (r_cnt == r_len_m1);
    assign w_end      = w_boundary && (row == w_last);
    assign w_rd_note  = note_tp'(w_rd_data[DW-1:SPLEN]);
    assign w_rd_speed = w_rd_data[SPLEN-1:0];

    // The read address always targets the row after the one being presented,
    // so the RAM read register doubles as the prefetch register.
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = '0;
        if (r_state == S_FETCH) begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_wait ? '0 : nxt('0, w_last);
        end else if (w_boundary) begin
            w_rd_en   = 1'b1;
            w_rd_addr = nxt(w_next_row, w_last);
        end
    end

    pattern_ram #(
        .ROWS  (ROWS),
        .WIDTH (DW)
    ) u_pattern_ram (
        .clk       (clk),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data ({wr_note, wr_speed}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait     <= 1'b0;
            r_cnt      <= '0;
            r_len_m1   <= TCLEN'(1);
            note       <= SILENT_NOTE;
            speed      <= '0;
            row        <= '0;
            playing    <= 1'b0;
            row_strobe <= 1'b0;
            done       <= 1'b0;
        end else begin
            row_strobe <= 1'b0;
            done       <= 1'b0;
            if (stop) begin
                r_state <= S_IDLE;
                note    <= SILENT_NOTE;
                speed   <= '0;
                row     <= '0;
                playing <= 1'b0;
            end else if (start) begin
                r_state <= S_FETCH;
                r_wait  <= 1'b1;
                note    <= SILENT_NOTE;
                speed   <= '0;
                row     <= '0;
                playing <= 1'b1;
            end else begin
                case (r_state)
                    S_FETCH: begin
                        if (r_wait) begin
                            r_wait <= 1'b0;
                        end else begin
                            note       <= w_rd_note;
                            speed      <= w_rd_speed;
                            row        <= '0;
                            row_strobe <= 1'b1;
                            r_cnt      <= '0;
                            r_len_m1   <= w_len_m1;
                            r_state    <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (w_end && !loop_en) begin
                            r_state <= S_IDLE;
                            note    <= SILENT_NOTE;
                            speed   <= '0;
                            row     <= '0;
                            playing <= 1'b0;
                            done    <= 1'b1;
                        end else if (w_boundary) begin
                            note       <= w_rd_note;
                            speed      <= w_rd_speed;
                            row        <= w_next_row;
                            row_strobe <= 1'b1;
                            r_cnt      <= '0;
                            r_len_m1   <= w_len_m1;
                        end else begin
                            r_cnt <= r_cnt + TCLEN'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tracker_sequencer.sv
// Directed bench for tracker_sequencer: rows k hold speed k+1 and a known note,
// and each scenario task checks outputs cycle by cycle against hand timing.
module tb_tracker_sequencer;
    import tracker_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [5:0]  wr_addr;
    note_tp      wr_note;
    logic [3:0]  wr_speed;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [5:0]  last_row;
    logic [15:0] row_len;
    note_tp      note;
    logic [3:0]  speed;
    logic [5:0]  row;
    logic        playing;
    logic        row_strobe;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    tracker_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_note    (wr_note),
        .wr_speed   (wr_speed),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .last_row   (last_row),
        .row_len    (row_len),
        .note       (note),
        .speed      (speed),
        .row        (row),
        .playing    (playing),
        .row_strobe (row_strobe),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic note_tp note_for(input int k);
        note_tp n;
        n.pitch = 6'(10 + k);
        n.instr = instrument_t'(2'(k));
        n.fx    = FX_NONE;
        return n;
    endfunction

    task automatic write_row(input int a, input int sp);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_addr  = 6'(a);
        wr_note  = note_for(a);
        wr_speed = 4'(sp);
        @(negedge clk);
        wr_en    = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({playing, row_strobe, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000", {playing, row_strobe, done});
        end
        n_tests++;
        if ({note, speed, row} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got note=%h speed=%0d row=%0d want 0", note, speed, row);
        end
    endtask

    // Generic pattern run: start sampled at edge 0, cycle c observed after edge c.
    task automatic test_pattern(input int len, input int last, input bit loop,
                                input int ncyc, input int stop_at);
        int eff, k;
        logic [5:0] erow;
        logic [3:0] esp;
        note_tp enote;
        logic estrobe, eplay, edone;
        eff = (len < 2) ? 2 : len;
        @(negedge clk);
        row_len  = 16'(len);
        last_row = 6'(last);
        loop_en  = loop;
        start    = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = (c == stop_at + 1);
            @(posedge clk);
            #1;
            eplay = 0; estrobe = 0; edone = 0; erow = '0; esp = '0; enote = SILENT_NOTE;
            if (stop_at >= 0 && c > stop_at) begin
                eplay = 0;
            end else if (c == 1) begin
                eplay = 1;
            end else begin
                k = (c - 2) / eff;
                if (!loop && k > last) begin
                    edone = (c == 2 + (last + 1) * eff);
                end else begin
                    eplay   = 1;
                    estrobe = ((c - 2) % eff == 0);
                    erow    = 6'(loop ? k % (last + 1) : k);
                    esp     = 4'(erow + 1);
                    enote   = note_for(int'(erow));
                end
            end
            n_tests++;
            if (playing !== eplay) begin
                n_fail++;
                $display("FAIL pattern_playing c=%0d: got %b want %b", c, playing, eplay);
            end
            n_tests++;
            if (row_strobe !== estrobe) begin
                n_fail++;
                $display("FAIL pattern_strobe c=%0d: got %b want %b", c, row_strobe, estrobe);
            end
            n_tests++;
            if (done !== edone) begin
                n_fail++;
                $display("FAIL pattern_done c=%0d: got %b want %b", c, done, edone);
            end
            if (c != 1) begin
                n_tests++;
                if ({note, speed, row} !== {enote, esp, erow}) begin
                    n_fail++;
                    $display("FAIL pattern_data c=%0d: got note=%h speed=%0d row=%0d want note=%h speed=%0d row=%0d",
                             c, note, speed, row, enote, esp, erow);
                end
            end
        end
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Restart at edge 7 (during row 1), then start+stop together at edge 13.
    task automatic test_restart;
        int base;
        logic [5:0] erow;
        logic estrobe, eplay, echk;
        @(negedge clk);
        row_len = 16'd4; last_row = 6'd3; loop_en = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = (c == 7) || (c == 13);
            stop  = (c == 13);
            @(posedge clk);
            #1;
            base = (c >= 9) ? 9 : 2;
            eplay = 0; estrobe = 0; erow = '0; echk = 1;
            if (c == 1 || c == 7 || c == 8) begin
                eplay = 1; echk = 0;
            end else if (c < 13) begin
                eplay   = 1;
                erow    = 6'((c - base) / 4);
                estrobe = ((c - base) % 4 == 0);
            end
            n_tests++;
            if ({playing, row_strobe, done} !== {eplay, estrobe, 1'b0}) begin
                n_fail++;
                $display("FAIL restart_flags c=%0d: got %b want %b", c,
                         {playing, row_strobe, done}, {eplay, estrobe, 1'b0});
            end
            if (echk) begin
                n_tests++;
                if ({row, speed} !== {erow, (c >= 13) ? 4'd0 : 4'(erow + 1)}) begin
                    n_fail++;
                    $display("FAIL restart_data c=%0d: got row=%0d speed=%0d want row=%0d", c, row, speed, erow);
                end
            end
        end
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    // Writes to already-prefetched rows (including a same-edge read/write)
    // must only show up on the next loop pass.
    task automatic test_write_prefetched;
        @(negedge clk);
        row_len = 16'd4; last_row = 6'd3; loop_en = 1'b1; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            start    = 1'b0;
            wr_en    = (c == 3) || (c == 6);
            wr_addr  = (c == 3) ? 6'd1 : 6'd2;
            wr_note  = note_for(int'(wr_addr));
            wr_speed = (c == 3) ? 4'd9 : 4'd7;
            stop     = (c == 28);
            @(posedge clk);
            #1;
            if (c == 6 || c == 10 || c == 22 || c == 26) begin
                n_tests++;
                if ({row, speed} !== {6'((c - 2) / 4 % 4),
                                      (c == 6) ? 4'd2 : (c == 10) ? 4'd3 : (c == 22) ? 4'd9 : 4'd7}) begin
                    n_fail++;
                    $display("FAIL prefetch_write c=%0d: got row=%0d speed=%0d", c, row, speed);
                end
            end
            if (c == 28) begin
                n_tests++;
                if (playing !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL prefetch_stop: got playing=%b done=%b want 0 0", playing, done);
                end
            end
        end
        @(negedge clk);
        stop = 1'b0; wr_en = 1'b0;
        write_row(1, 2);
        write_row(2, 3);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        row_len = 16'd4; last_row = 6'd3; loop_en = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (playing !== 1'b1 || row !== 6'd0 || speed !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got playing=%b row=%0d speed=%0d want 1 0 1", playing, row, speed);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({playing, row_strobe, done, note, speed, row} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got playing=%b note=%h speed=%0d row=%0d want all 0",
                     playing, note, speed, row);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_pattern(4, 3, 0, 19, -1);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_note = SILENT_NOTE; wr_speed = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; last_row = '0; row_len = '0;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) write_row(i, i + 1);
        test_pattern(4, 3, 0, 22, -1);
        test_pattern(4, 3, 1, 22, 20);
        test_pattern(0, 1, 0, 8, -1);
        test_pattern(1, 0, 0, 5, -1);
        test_restart;
        test_write_prefetched;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
